reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order reorder buffer between the decoder/issue stage and the register file.
- Allocates ROB ids at issue and broadcasts the launch (rd renaming) to the register file.
- Collects execution results from the writeback bus and commits one entry per cycle, in order, to the register file.
- Detects branch mispredictions at commit, then raises a one-cycle pipeline clear with the redirect PC.

Parameters:
- DEPTH, 31, number of entries. Valid ROB ids are 1..DEPTH; id 0 is reserved and means "no dependency".

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset. Synchronous and active-low: state is reset on the posedge where rst_in==0.
- rdy_in  in  1  ready; when low, all state freezes
- _issue_valid  in  1  decoder presents an instruction
- _issue_rd  in  5  destination register (0 = none)
- _issue_is_branch  in  1  instruction is a conditional branch or jalr
- _issue_pred_taken  in  1  predicted direction
- _issue_alt_pc  in  32  PC to redirect to if the prediction proves wrong
- _rob_full  out  1  combinational, count==DEPTH
- _rob_tail_id  out  5  id the next accepted issue receives
- _rob_launch_ready  out  1  combinational, issue accepted this cycle
- _rob_launch_rob_id  out  5  = _rob_tail_id
- _rob_launch_register_id  out  5  = _issue_rd
- _wb_valid  in  1  result broadcast valid
- _wb_rob_id  in  5  producing entry
- _wb_value  in  32  result value
- _wb_taken  in  1  actual branch direction
- _ask_id_1, _ask_id_2  in  5  operand ROB-id queries
- _ask_ready_1, _ask_ready_2  out  1  combinational, entry busy and result ready
- _ask_value_1, _ask_value_2  out  32  combinational, entry value
- _rob_commit_ready  out  1  registered commit pulse
- _rob_commit_rob_id  out  5  committed id
- _rob_commit_register_id  out  5  committed rd
- _rob_commit_value  out  32  committed value
- _clear  out  1  registered flush pulse
- _clear_pc  out  32  redirect PC, valid with _clear

Behaviour:
- Reset (rst_in==0 at posedge):
  - head=tail=1, count=0, all entries not busy.
  - All registered outputs are 0.
  - _rob_tail_id reads 1.
- rdy_in low:
  - No state changes.
  - _rob_launch_ready is forced to 0.
  - Registered outputs hold their values.
- Issue acceptance:
  - Accept = rdy_in && _issue_valid && !_rob_full && !_clear.
  - On accept, entry[tail] gets busy=1, ready=0, rd, is_branch, pred, alt_pc.
  - Tail advances, wrapping from DEPTH to 1 (never 0).
  - Launch outputs are asserted the same cycle, so the register file records the dependency at this edge.
- Writeback:
  - If _wb_valid and entry[_wb_rob_id] is busy, the entry latches value and taken and sets ready=1.
  - Writeback to id 0 or to a non-busy id is ignored.
- Commit:
  - Evaluated on the registered state at each edge.
  - If entry[head] is busy and ready: drive the commit outputs next cycle with _rob_commit_ready=1, clear busy, advance head (with wrap), and decrement count.
  - Otherwise _rob_commit_ready=0.
  - A writeback to head in cycle N commits no earlier than edge N+1, giving a one-cycle minimum result-to-commit latency.
- Mispredict:
  - Applies when the committing entry has is_branch and taken != pred.
  - The commit pulse is still issued; rd commits normally (jalr link).
  - Also registered: _clear=1 and _clear_pc=alt_pc.
  - Consumers see the commit and the clear in the same cycle.
- While _clear==1:
  - Issue, writeback and commit are suppressed.
  - All busy bits clear, head=tail=1, count=0.
  - _clear and _rob_commit_ready return to 0 next cycle.
- Simultaneous issue + commit: count unchanged.
  - At full, a commit does not enable a same-cycle issue, because full is computed from the registered count.
- Issue + writeback to the same id in one cycle: impossible by construction (the id is not yet busy), so the writeback is ignored.
- Query ports read entry state directly.
  - A same-cycle writeback is not forwarded; the decoder also checks the _wb bus.
- rd==0 entries commit with _rob_commit_register_id=0; the register file discards them.

Test Plan:
- Reset then issue rd=5 -> _rob_launch_ready=1 with id 1. Then wb id1 value 0xDEADBEEF -> next cycle commit_ready=1, id=1, reg=5, value=0xDEADBEEF.
- Issue ids 1,2,3; wb in order 3,1,2 -> commits strictly in order 1,2,3 on consecutive cycles after wb of id 2.
- Fill 31 entries -> _rob_full=1, issue ignored. Commit id 1 -> count 30, the next issue gets id 1 (wrap check).
- Branch at id 4, pred_taken=0, wb taken=1, alt_pc=0x1000 -> commit id 4 and _clear=1, _clear_pc=0x1000 in the same cycle. Next cycle: count=0, _rob_tail_id=1.
- Hold rdy_in=0 for 3 cycles during pending wb/commit -> no pointer or output change; sequence resumes identically.
- Assert rst_in=0 mid-operation with 10 busy entries -> next cycle all outputs 0, tail id 1, _ask_ready_x=0 for all ids.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: hands out ROB ids at issue, collects writeback
// results, commits one entry per cycle in order and flushes the pipeline on a mispredict.
module reorder_buffer #(
  parameter int DEPTH = 31
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _issue_valid,
  input  logic [4:0]  _issue_rd,
  input  logic        _issue_is_branch,
  input  logic        _issue_pred_taken,
  input  logic [31:0] _issue_alt_pc,
  output logic        _rob_full,
  output logic [4:0]  _rob_tail_id,
  output logic        _rob_launch_ready,
  output logic [4:0]  _rob_launch_rob_id,
  output logic [4:0]  _rob_launch_register_id,
  input  logic        _wb_valid,
  input  logic [4:0]  _wb_rob_id,
  input  logic [31:0] _wb_value,
  input  logic        _wb_taken,
  input  logic [4:0]  _ask_id_1,
  input  logic [4:0]  _ask_id_2,
  output logic        _ask_ready_1,
  output logic        _ask_ready_2,
  output logic [31:0] _ask_value_1,
  output logic [31:0] _ask_value_2,
  output logic        _rob_commit_ready,
  output logic [4:0]  _rob_commit_rob_id,
  output logic [4:0]  _rob_commit_register_id,
  output logic [31:0] _rob_commit_value,
  output logic        _clear,
  output logic [31:0] _clear_pc
);
  localparam int         SLOTS    = 32;
  localparam logic [4:0] LAST_ID  = 5'(DEPTH);
  localparam logic [5:0] FULL_CNT = 6'(DEPTH);

  logic [4:0]  head_q, head_d, tail_q, tail_d;
  logic [5:0]  count_q, count_d;
  logic [SLOTS-1:0] busy_q, busy_d, ready_q, ready_d;
  logic [SLOTS-1:0] br_q, br_d, pred_q, pred_d, taken_q, taken_d;
  logic [4:0]  rd_q [SLOTS];
  logic [4:0]  rd_d [SLOTS];
  logic [31:0] value_q [SLOTS];
  logic [31:0] value_d [SLOTS];
  logic [31:0] alt_q [SLOTS];
  logic [31:0] alt_d [SLOTS];

  logic        commit_ready_q, commit_ready_d;
  logic [4:0]  commit_id_q, commit_id_d, commit_reg_q, commit_reg_d;
  logic [31:0] commit_value_q, commit_value_d;
  logic        clear_q, clear_d;
  logic [31:0] clear_pc_q, clear_pc_d;

  logic accept, wb_hit, commit_go, mispredict;

  // Ids run 1..DEPTH; id 0 means "no dependency" and is never allocated.
  function automatic logic [4:0] next_id(input logic [4:0] id);
    return (id == LAST_ID) ? 5'd1 : id + 5'd1;
  endfunction

  function automatic logic id_ok(input logic [4:0] id);
    return (id != 5'd0) && (int'(id) <= DEPTH);
  endfunction

  assign _rob_full               = (count_q == FULL_CNT);
  assign accept                  = rdy_in & _issue_valid & ~_rob_full & ~clear_q;
  assign _rob_tail_id            = tail_q;
  assign _rob_launch_ready       = accept;
  assign _rob_launch_rob_id      = tail_q;
  assign _rob_launch_register_id = _issue_rd;

  assign wb_hit     = _wb_valid & id_ok(_wb_rob_id) & busy_q[_wb_rob_id];
  assign commit_go  = busy_q[head_q] & ready_q[head_q];
  assign mispredict = commit_go & br_q[head_q] & (taken_q[head_q] != pred_q[head_q]);

  assign _ask_ready_1 = id_ok(_ask_id_1) & busy_q[_ask_id_1] & ready_q[_ask_id_1];
  assign _ask_ready_2 = id_ok(_ask_id_2) & busy_q[_ask_id_2] & ready_q[_ask_id_2];
  assign _ask_value_1 = value_q[_ask_id_1];
  assign _ask_value_2 = value_q[_ask_id_2];

  assign _rob_commit_ready       = commit_ready_q;
  assign _rob_commit_rob_id      = commit_id_q;
  assign _rob_commit_register_id = commit_reg_q;
  assign _rob_commit_value       = commit_value_q;
  assign _clear                  = clear_q;
  assign _clear_pc               = clear_pc_q;

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    ready_d        = ready_q;
    br_d           = br_q;
    pred_d         = pred_q;
    taken_d        = taken_q;
    rd_d           = rd_q;
    value_d        = value_q;
    alt_d          = alt_q;
    commit_ready_d = commit_ready_q;
    commit_id_d    = commit_id_q;
    commit_reg_d   = commit_reg_q;
    commit_value_d = commit_value_q;
    clear_d        = clear_q;
    clear_pc_d     = clear_pc_q;

    if (rdy_in) begin
      if (clear_q) begin
        // Flush cycle: everything younger than the mispredicted branch is dropped.
        busy_d         = '0;
        ready_d        = '0;
        head_d         = 5'd1;
        tail_d         = 5'd1;
        count_d        = 6'd0;
        commit_ready_d = 1'b0;
        clear_d        = 1'b0;
      end else begin
        if (wb_hit) begin
          value_d[_wb_rob_id] = _wb_value;
          taken_d[_wb_rob_id] = _wb_taken;
          ready_d[_wb_rob_id] = 1'b1;
        end
        commit_ready_d = commit_go;
        clear_d        = mispredict;
        if (commit_go) begin
          commit_id_d     = head_q;
          commit_reg_d    = rd_q[head_q];
          commit_value_d  = value_q[head_q];
          busy_d[head_q]  = 1'b0;
          head_d          = next_id(head_q);
        end
        if (mispredict) begin
          clear_pc_d = alt_q[head_q];
        end
        if (accept) begin
          busy_d[tail_q]  = 1'b1;
          ready_d[tail_q] = 1'b0;
          rd_d[tail_q]    = _issue_rd;
          br_d[tail_q]    = _issue_is_branch;
          pred_d[tail_q]  = _issue_pred_taken;
          alt_d[tail_q]   = _issue_alt_pc;
          tail_d          = next_id(tail_q);
        end
        count_d = count_q + {5'd0, accept} - {5'd0, commit_go};
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q         <= 5'd1;
      tail_q         <= 5'd1;
      count_q        <= 6'd0;
      busy_q         <= '0;
      ready_q        <= '0;
      commit_ready_q <= 1'b0;
      commit_id_q    <= 5'd0;
      commit_reg_q   <= 5'd0;
      commit_value_q <= 32'd0;
      clear_q        <= 1'b0;
      clear_pc_q     <= 32'd0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      commit_ready_q <= commit_ready_d;
      commit_id_q    <= commit_id_d;
      commit_reg_q   <= commit_reg_d;
      commit_value_q <= commit_value_d;
      clear_q        <= clear_d;
      clear_pc_q     <= clear_pc_d;
    end
  end

  // Payload is only read while its busy bit is set, so it needs no reset.
  always_ff @(posedge clk_in) begin
    br_q    <= br_d;
    pred_q  <= pred_d;
    taken_q <= taken_d;
    rd_q    <= rd_d;
    value_q <= value_d;
    alt_q   <= alt_d;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: vector table for the basic flows, a commit
// scoreboard fed at issue/writeback time, and hand sequences for full/flush/stall/reset.
module tb_reorder_buffer;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        _issue_valid = 1'b0;
  logic [4:0]  _issue_rd = '0;
  logic        _issue_is_branch = 1'b0;
  logic        _issue_pred_taken = 1'b0;
  logic [31:0] _issue_alt_pc = '0;
  logic        _rob_full;
  logic [4:0]  _rob_tail_id;
  logic        _rob_launch_ready;
  logic [4:0]  _rob_launch_rob_id;
  logic [4:0]  _rob_launch_register_id;
  logic        _wb_valid = 1'b0;
  logic [4:0]  _wb_rob_id = '0;
  logic [31:0] _wb_value = '0;
  logic        _wb_taken = 1'b0;
  logic [4:0]  _ask_id_1 = '0;
  logic [4:0]  _ask_id_2 = '0;
  logic        _ask_ready_1, _ask_ready_2;
  logic [31:0] _ask_value_1, _ask_value_2;
  logic        _rob_commit_ready;
  logic [4:0]  _rob_commit_rob_id;
  logic [4:0]  _rob_commit_register_id;
  logic [31:0] _rob_commit_value;
  logic        _clear;
  logic [31:0] _clear_pc;

  reorder_buffer #(.DEPTH(31)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    ._issue_valid(_issue_valid), ._issue_rd(_issue_rd), ._issue_is_branch(_issue_is_branch),
    ._issue_pred_taken(_issue_pred_taken), ._issue_alt_pc(_issue_alt_pc),
    ._rob_full(_rob_full), ._rob_tail_id(_rob_tail_id), ._rob_launch_ready(_rob_launch_ready),
    ._rob_launch_rob_id(_rob_launch_rob_id), ._rob_launch_register_id(_rob_launch_register_id),
    ._wb_valid(_wb_valid), ._wb_rob_id(_wb_rob_id), ._wb_value(_wb_value), ._wb_taken(_wb_taken),
    ._ask_id_1(_ask_id_1), ._ask_id_2(_ask_id_2), ._ask_ready_1(_ask_ready_1),
    ._ask_ready_2(_ask_ready_2), ._ask_value_1(_ask_value_1), ._ask_value_2(_ask_value_2),
    ._rob_commit_ready(_rob_commit_ready), ._rob_commit_rob_id(_rob_commit_rob_id),
    ._rob_commit_register_id(_rob_commit_register_id), ._rob_commit_value(_rob_commit_value),
    ._clear(_clear), ._clear_pc(_clear_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0]  id;
    logic [4:0]  rd;
    bit          br;
    bit          pred;
    logic [31:0] alt;
  } sb_t;

  typedef struct {
    bit          rst;
    bit          iv;
    logic [4:0]  rd;
    bit          wv;
    logic [4:0]  wid;
    logic [31:0] wval;
    bit          e_l;
    logic [4:0]  e_lid;
    bit          e_cr;
    logic [4:0]  e_cid;
    logic [4:0]  e_creg;
    logic [31:0] e_cval;
  } vec_t;

  sb_t         sb_q[$];
  logic [31:0] mval [32];
  bit          mtaken [32];
  int          m_tail = 1;
  int          m_count = 0;
  bit          m_clear = 0;
  int          errors = 0;
  int          checks = 0;
  vec_t        tbl [13];

  function automatic vec_t mk(int rst, int iv, int rd, int wv, int wid, logic [31:0] wval,
                              int el, int lid, int cr, int cid, int creg, logic [31:0] cval);
    vec_t v;
    v.rst = (rst != 0); v.iv = (iv != 0); v.rd = 5'(rd);
    v.wv = (wv != 0); v.wid = 5'(wid); v.wval = wval;
    v.e_l = (el != 0); v.e_lid = 5'(lid);
    v.e_cr = (cr != 0); v.e_cid = 5'(cid); v.e_creg = 5'(creg); v.e_cval = cval;
    return v;
  endfunction

  function automatic bit in_sb(logic [4:0] id);
    foreach (sb_q[i]) if (sb_q[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and check the combinational launch response.
  task automatic drive(input bit iv, input logic [4:0] rd, input bit br, input bit pred,
                       input logic [31:0] alt, input bit wv, input logic [4:0] wid,
                       input logic [31:0] wval, input bit wtaken);
    bit  exp_acc;
    sb_t e;
    _issue_valid = iv; _issue_rd = rd; _issue_is_branch = br;
    _issue_pred_taken = pred; _issue_alt_pc = alt;
    _wb_valid = wv; _wb_rob_id = wid; _wb_value = wval; _wb_taken = wtaken;
    #1;
    exp_acc = iv && rdy_in && !m_clear && (m_count < 31);
    chk("launch_ready", 32'(_rob_launch_ready), 32'(exp_acc));
    if (exp_acc) begin
      chk("launch_id", 32'(_rob_launch_rob_id), 32'(m_tail));
      chk("launch_reg", 32'(_rob_launch_register_id), 32'(rd));
      e.id = 5'(m_tail); e.rd = rd; e.br = br; e.pred = pred; e.alt = alt;
      sb_q.push_back(e);
      m_tail = (m_tail == 31) ? 1 : m_tail + 1;
      m_count++;
    end
    if (wv && rdy_in && !m_clear && in_sb(wid)) begin
      mval[wid]   = wval;
      mtaken[wid] = wtaken;
    end
  endtask

  task automatic idle_in();
    drive(0, 5'd0, 0, 0, 32'd0, 0, 5'd0, 32'd0, 0);
  endtask

  // Advance one clock and score any commit the DUT reports.
  task automatic tick();
    bit  was_rdy, was_rst, exp_clr;
    sb_t e;
    was_rdy = rdy_in;
    was_rst = rst_in;
    @(posedge clk_in);
    #1;
    if (was_rst && was_rdy) begin
      m_clear = 0;
      if (_rob_commit_ready) begin
        if (sb_q.size() == 0) begin
          chk("commit_unexpected", 32'(_rob_commit_rob_id), 32'd0);
        end else begin
          e = sb_q.pop_front();
          exp_clr = e.br && (mtaken[e.id] != e.pred);
          $display("commit id=%0d reg=%0d value=%h clear=%0d", _rob_commit_rob_id,
                   _rob_commit_register_id, _rob_commit_value, _clear);
          chk("commit_id", 32'(_rob_commit_rob_id), 32'(e.id));
          chk("commit_reg", 32'(_rob_commit_register_id), 32'(e.rd));
          chk("commit_value", _rob_commit_value, mval[e.id]);
          chk("commit_clear", 32'(_clear), 32'(exp_clr));
          m_count--;
          if (exp_clr) begin
            chk("commit_clear_pc", _clear_pc, e.alt);
            sb_q.delete();
            m_tail = 1; m_count = 0; m_clear = 1;
          end
        end
      end else begin
        chk("idle_clear", 32'(_clear), 32'd0);
      end
    end
  endtask

  task automatic cyc_issue(input logic [4:0] rd);
    drive(1, rd, 0, 0, 32'd0, 0, 5'd0, 32'd0, 0);
    tick();
  endtask

  task automatic cyc_wb(input logic [4:0] id, input logic [31:0] val, input bit tk);
    drive(0, 5'd0, 0, 0, 32'd0, 1, id, val, tk);
    tick();
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    idle_in();
    tick();
    rst_in = 1'b1;
    sb_q.delete();
    m_tail = 1; m_count = 0; m_clear = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    tbl[0]  = mk(1, 1, 5, 0, 0, 32'h0,        1, 1, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 1, 5, 32'hDEADBEEF);
    tbl[3]  = mk(0, 0, 0, 1, 9, 32'h77,       0, 0, 0, 0, 0, 32'h0);
    tbl[4]  = mk(1, 1, 1, 0, 0, 32'h0,        1, 1, 0, 0, 0, 32'h0);
    tbl[5]  = mk(0, 1, 2, 0, 0, 32'h0,        1, 2, 0, 0, 0, 32'h0);
    tbl[6]  = mk(0, 1, 3, 0, 0, 32'h0,        1, 3, 0, 0, 0, 32'h0);
    tbl[7]  = mk(0, 0, 0, 1, 3, 32'h33,       0, 0, 0, 0, 0, 32'h0);
    tbl[8]  = mk(0, 0, 0, 1, 1, 32'h11,       0, 0, 0, 0, 0, 32'h0);
    tbl[9]  = mk(0, 0, 0, 1, 2, 32'h22,       0, 0, 1, 1, 1, 32'h11);
    tbl[10] = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 2, 2, 32'h22);
    tbl[11] = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 3, 3, 32'h33);
    tbl[12] = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0);

    do_reset();
    chk("rst_commit_ready", 32'(_rob_commit_ready), 32'd0);
    chk("rst_commit_id", 32'(_rob_commit_rob_id), 32'd0);
    chk("rst_commit_value", _rob_commit_value, 32'd0);
    chk("rst_clear", 32'(_clear), 32'd0);
    chk("rst_clear_pc", _clear_pc, 32'd0);
    chk("rst_tail", 32'(_rob_tail_id), 32'd1);
    chk("rst_full", 32'(_rob_full), 32'd0);

    // Single issue/commit and out-of-order writeback with in-order commit.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].iv, tbl[i].rd, 0, 0, 32'd0, tbl[i].wv, tbl[i].wid, tbl[i].wval, 0);
      chk("tbl_launch", 32'(_rob_launch_ready), 32'(tbl[i].e_l));
      if (tbl[i].e_l) chk("tbl_launch_id", 32'(_rob_launch_rob_id), 32'(tbl[i].e_lid));
      tick();
      chk("tbl_commit_ready", 32'(_rob_commit_ready), 32'(tbl[i].e_cr));
      if (tbl[i].e_cr) begin
        chk("tbl_commit_id", 32'(_rob_commit_rob_id), 32'(tbl[i].e_cid));
        chk("tbl_commit_reg", 32'(_rob_commit_register_id), 32'(tbl[i].e_creg));
        chk("tbl_commit_value", _rob_commit_value, tbl[i].e_cval);
      end
    end

    // Fill to capacity, then free one slot and confirm the id wraps to 1.
    do_reset();
    for (int i = 0; i < 31; i++) cyc_issue(5'(i));
    chk("full_flag", 32'(_rob_full), 32'd1);
    chk("full_tail_wrap", 32'(_rob_tail_id), 32'd1);
    drive(1, 5'd3, 0, 0, 32'd0, 1, 5'd1, 32'h1111, 0);
    chk("full_reject", 32'(_rob_launch_ready), 32'd0);
    tick();
    drive(1, 5'd3, 0, 0, 32'd0, 0, 5'd0, 32'd0, 0);
    chk("full_commit_no_issue", 32'(_rob_launch_ready), 32'd0);
    tick();
    chk("full_after_commit", 32'(_rob_full), 32'd0);
    drive(1, 5'd4, 0, 0, 32'd0, 0, 5'd0, 32'd0, 0);
    chk("wrap_id", 32'(_rob_launch_rob_id), 32'd1);
    tick();

    // Mispredicted branch at id 4 flushes the younger id 5.
    do_reset();
    cyc_issue(5'd1);
    cyc_issue(5'd2);
    cyc_issue(5'd3);
    drive(1, 5'd7, 1, 0, 32'h1000, 0, 5'd0, 32'd0, 0);
    tick();
    cyc_issue(5'd8);
    got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      if (c < 5) drive(0, 5'd0, 0, 0, 32'd0, 1, 5'(c + 1), 32'h100 * (c + 1), (c == 3));
      else idle_in();
      tick();
      if (_clear) got = 1;
    end
    chk("mispredict_seen", 32'(got), 32'd1);
    chk("mispredict_commit", 32'(_rob_commit_ready), 32'd1);
    chk("mispredict_id", 32'(_rob_commit_rob_id), 32'd4);
    chk("mispredict_pc", _clear_pc, 32'h1000);
    _ask_id_1 = 5'd5;
    drive(1, 5'd12, 0, 0, 32'd0, 0, 5'd0, 32'd0, 0);
    chk("flush_blocks_issue", 32'(_rob_launch_ready), 32'd0);
    tick();
    chk("flush_tail", 32'(_rob_tail_id), 32'd1);
    chk("flush_clear_drop", 32'(_clear), 32'd0);
    chk("flush_commit_drop", 32'(_rob_commit_ready), 32'd0);
    chk("flush_busy_gone", 32'(_ask_ready_1), 32'd0);
    drive(1, 5'd2, 0, 0, 32'd0, 0, 5'd0, 32'd0, 0);
    chk("flush_next_id", 32'(_rob_launch_rob_id), 32'd1);
    tick();

    // Stall with a commit on the outputs: nothing may move while rdy_in is low.
    do_reset();
    cyc_issue(5'd9);
    cyc_issue(5'd10);
    cyc_wb(5'd1, 32'h99, 0);
    cyc_wb(5'd2, 32'hAA, 0);
    chk("pre_hold_commit", 32'(_rob_commit_ready), 32'd1);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd11, 0, 0, 32'd0, 1, 5'd2, 32'hBB, 0);
      chk("hold_launch", 32'(_rob_launch_ready), 32'd0);
      tick();
      chk("hold_commit_ready", 32'(_rob_commit_ready), 32'd1);
      chk("hold_commit_id", 32'(_rob_commit_rob_id), 32'd1);
      chk("hold_commit_value", _rob_commit_value, 32'h99);
      chk("hold_tail", 32'(_rob_tail_id), 32'd3);
    end
    rdy_in = 1'b1;
    idle_in();
    tick();
    chk("resume_commit_id", 32'(_rob_commit_rob_id), 32'd2);
    chk("resume_commit_value", _rob_commit_value, 32'hAA);
    idle_in();
    tick();

    // Reset in the middle of traffic with ten busy entries.
    do_reset();
    for (int i = 0; i < 10; i++) cyc_issue(5'(i + 1));
    for (int i = 2; i <= 6; i++) cyc_wb(5'(i), 32'h600 + 32'(i), 0);
    cyc_wb(5'd20, 32'hBAD, 0);
    _ask_id_1 = 5'd3;
    _ask_id_2 = 5'd4;
    #1;
    chk("ask_ready_1", 32'(_ask_ready_1), 32'd1);
    chk("ask_value_1", _ask_value_1, mval[3]);
    chk("ask_ready_2", 32'(_ask_ready_2), 32'd1);
    chk("ask_value_2", _ask_value_2, mval[4]);
    _ask_id_2 = 5'd20;
    #1;
    chk("ask_nonbusy", 32'(_ask_ready_2), 32'd0);
    do_reset();
    chk("midrst_commit_ready", 32'(_rob_commit_ready), 32'd0);
    chk("midrst_commit_reg", 32'(_rob_commit_register_id), 32'd0);
    chk("midrst_clear", 32'(_clear), 32'd0);
    chk("midrst_tail", 32'(_rob_tail_id), 32'd1);
    chk("midrst_full", 32'(_rob_full), 32'd0);
    for (int i = 0; i < 32; i++) begin
      _ask_id_1 = 5'(i);
      _ask_id_2 = 5'(31 - i);
      #1;
      chk("midrst_ask_1", 32'(_ask_ready_1), 32'd0);
      chk("midrst_ask_2", 32'(_ask_ready_2), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
